// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer/compare unit: FSM state encoding,
// default geometry and sticky-flag bit positions.
package timer_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NCH   = 2;
  localparam int DEF_PSC_W = 8;

  localparam int FLAG_PR   = 0;
  localparam int FLAG_CMP0 = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tmr_state_t;
endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts 0..psc while running and emits a tick on the
// terminal count; held at zero whenever the timer is not running.
module timer_prescaler #(
  parameter int PSC_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [PSC_W-1:0] psc,
  output logic             tick
);
  logic [PSC_W-1:0] cnt;

  assign tick = run && (cnt == psc);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)            cnt <= '0;
    else if (!run || tick) cnt <= '0;
    else                   cnt <= cnt + 1'b1;
endmodule

// File: rtl/timer_cmp_unit.sv
// Prescaled up-counter with shadowed period/compare registers, NCH compare
// channels, sticky flags and one-shot mode. PWM outputs exist when TIMER_PWM_EN is defined.
module timer_cmp_unit
  import timer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NCH   = DEF_NCH,
  parameter int PSC_W = DEF_PSC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               one_shot,
  input  logic [PSC_W-1:0]   psc,
  input  logic               pr_we,
  input  logic [WIDTH-1:0]   pr_wdata,
  input  logic [NCH-1:0]     cmp_we,
  input  logic [NCH*WIDTH-1:0] cmp_wdata,
  input  logic [NCH:0]       flag_clr,
  output logic [WIDTH-1:0]   tmr,
  output logic               pr_match,
  output logic [NCH-1:0]     cmp_match,
  output logic [NCH:0]       flags,
  output logic               irq,
  output logic               busy,
  output logic [NCH-1:0]     pwm_out
);
  tmr_state_t state, st_n;
  logic os_lat, tick, pr_ev, run;
  logic [WIDTH-1:0] tmr_n, pr_sh, pr_act, pr_act_n;
  logic [NCH-1:0][WIDTH-1:0] cmp_wd, cmp_sh, cmp_act, cmp_sh_n, cmp_act_n;
  logic [NCH-1:0] cmp_hit;
  logic [NCH:0] fl_set;

  assign run    = (state == RUN);
  assign busy   = run;
  assign irq    = |flags;
  assign cmp_wd = cmp_wdata;

  timer_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk(clk), .rst_n(rst_n), .run(run), .psc(psc), .tick(tick)
  );

  always_comb begin
    pr_ev = tick && (tmr == pr_act);
    tmr_n = tmr;
    if (tick) tmr_n = pr_ev ? '0 : tmr + 1'b1;
    st_n = state;
    case (state)
      IDLE:    if (en) st_n = RUN;
      RUN:     if (!en) st_n = IDLE;
               else if (pr_ev && os_lat) st_n = DONE;
      DONE:    if (!en) st_n = IDLE;
      default: st_n = IDLE;
    endcase
    // Outside RUN a write lands in active directly; in RUN only the reload moves it.
    pr_act_n = pr_act;
    if (!run && pr_we) pr_act_n = pr_wdata;
    else if (pr_ev)    pr_act_n = pr_sh;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign cmp_hit[i]   = tick && (tmr == cmp_act[i]);
    assign cmp_sh_n[i]  = cmp_we[i] ? cmp_wd[i] : cmp_sh[i];
    assign cmp_act_n[i] = (!run && cmp_we[i]) ? cmp_wd[i] :
                          pr_ev ? cmp_sh[i] : cmp_act[i];
  end

  assign fl_set[FLAG_PR]         = pr_ev;
  assign fl_set[FLAG_CMP0 +: NCH] = cmp_hit;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      os_lat    <= 1'b0;
      tmr       <= '0;
      pr_sh     <= '1;
      pr_act    <= '1;
      cmp_sh    <= '0;
      cmp_act   <= '0;
      pr_match  <= 1'b0;
      cmp_match <= '0;
      flags     <= '0;
    end else begin
      state     <= st_n;
      if (state == IDLE && en) os_lat <= one_shot;
      tmr       <= tmr_n;
      if (pr_we) pr_sh <= pr_wdata;
      pr_act    <= pr_act_n;
      cmp_sh    <= cmp_sh_n;
      cmp_act   <= cmp_act_n;
      pr_match  <= pr_ev;
      cmp_match <= cmp_hit;
      flags     <= fl_set | (flags & ~flag_clr);
    end

`ifdef TIMER_PWM_EN
  // Evaluated on next-state values so pwm_out lines up with the visible tmr.
  logic [NCH-1:0] pwm_n;
  for (genvar i = 0; i < NCH; i++) begin : g_pwm
    assign pwm_n[i] = (st_n == RUN) && (tmr_n < cmp_act_n[i]);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pwm_out <= '0;
    else        pwm_out <= pwm_n;
`else
  assign pwm_out = '0;
`endif
endmodule

// File: tb/tb_timer_cmp_unit.sv
// Scoreboard bench for timer_cmp_unit: expected per-cycle outputs are queued
// when a scenario starts and popped against the DUT one cycle at a time.
module tb_timer_cmp_unit;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, one_shot = 1'b0;
  logic [7:0]  psc = '0;
  logic        pr_we = 1'b0;
  logic [15:0] pr_wdata = '0;
  logic [1:0]  cmp_we = '0;
  logic [31:0] cmp_wdata = '0;
  logic [2:0]  flag_clr = '0;
  logic [15:0] tmr;
  logic        pr_match, irq, busy;
  logic [1:0]  cmp_match, pwm_out;
  logic [2:0]  flags;

  int n_tests = 0, n_fail = 0;

  typedef struct packed {
    logic [15:0] tmr;
    logic        pr;
    logic [1:0]  cmp;
    logic [2:0]  flg;
    logic        busy;
  } exp_t;

  exp_t sb[$];

  timer_cmp_unit dut (
    .clk(clk), .rst_n(rst_n), .en(en), .one_shot(one_shot), .psc(psc),
    .pr_we(pr_we), .pr_wdata(pr_wdata), .cmp_we(cmp_we), .cmp_wdata(cmp_wdata),
    .flag_clr(flag_clr), .tmr(tmr), .pr_match(pr_match), .cmp_match(cmp_match),
    .flags(flags), .irq(irq), .busy(busy), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; one_shot = 1'b0; pr_we = 1'b0; cmp_we = '0; flag_clr = '0;
    step(); step();
    rst_n = 1'b1;
  endtask

  // Program in IDLE, then enable; returns just after the IDLE->RUN edge (sample k=0).
  task automatic cfg_start(int p, int pr, int c0, int c1, logic os);
    do_reset();
    psc = 8'(p); pr_we = 1'b1; pr_wdata = 16'(pr);
    cmp_we = 2'b11; cmp_wdata = {16'(c1), 16'(c0)};
    step();
    pr_we = 1'b0; cmp_we = '0; en = 1'b1; one_shot = os;
    step();
  endtask

  // Continuous-mode expectation k samples after entering RUN.
  function automatic exp_t model(int p, int pr, int c0, int c1, int k);
    exp_t e;
    int n, pre;
    logic tk;
    e = '0;
    for (int j = 0; j <= k; j++) begin
      tk  = (j > 0) && (j % (p + 1) == 0);
      n   = j / (p + 1);
      pre = tk ? (n - 1) % (pr + 1) : -1;
      e.pr     = tk && (pre == pr);
      e.cmp[0] = tk && (pre == c0);
      e.cmp[1] = tk && (pre == c1);
      e.flg    = e.flg | {e.cmp, e.pr};
    end
    e.tmr  = 16'((k / (p + 1)) % (pr + 1));
    e.busy = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({tmr, pr_match, cmp_match, flags, irq, busy, pwm_out} !== '0) begin
      n_fail++;
      $display("FAIL reset got tmr=%0d pr=%b cmp=%b flg=%b irq=%b busy=%b pwm=%b exp all 0",
               tmr, pr_match, cmp_match, flags, irq, busy, pwm_out);
    end
  endtask

  task automatic test_basic_period();
    exp_t e;
    cfg_start(0, 4, 7, 8, 1'b0);
    for (int k = 0; k < 8; k++) sb.push_back(model(0, 4, 7, 8, k));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      e = sb.pop_front();
      n_tests++;
      if ({tmr, pr_match, cmp_match, flags, irq, busy} !== {e.tmr, e.pr, e.cmp, e.flg, |e.flg, e.busy}) begin
        n_fail++;
        $display("FAIL basic_period k=%0d got tmr=%0d pr=%b cmp=%b flg=%b irq=%b busy=%b exp tmr=%0d pr=%b cmp=%b flg=%b busy=%b",
                 k, tmr, pr_match, cmp_match, flags, irq, busy, e.tmr, e.pr, e.cmp, e.flg, e.busy);
      end
    end
  endtask

  task automatic test_prescale_flagclr();
    exp_t e;
    cfg_start(2, 3, 1, 3, 1'b0);
    for (int k = 0; k < 25; k++) sb.push_back(model(2, 3, 1, 3, k));
    for (int k = 0; k < 25; k++) begin
      if (k > 0) step();
      e = sb.pop_front();
      n_tests++;
      if ({tmr, pr_match, cmp_match, flags, irq, busy} !== {e.tmr, e.pr, e.cmp, e.flg, |e.flg, e.busy}) begin
        n_fail++;
        $display("FAIL prescale k=%0d got tmr=%0d pr=%b cmp=%b flg=%b irq=%b exp tmr=%0d pr=%b cmp=%b flg=%b",
                 k, tmr, pr_match, cmp_match, flags, irq, e.tmr, e.pr, e.cmp, e.flg);
      end
      if (k == 23) flag_clr = 3'b001;
    end
    // Sample 24 carried a period event together with the clear: set wins.
    step();
    n_tests++;
    if (flags !== 3'b110) begin
      n_fail++;
      $display("FAIL flag_clr_alone got flg=%b exp 110", flags);
    end
    flag_clr = 3'b110;
    step();
    flag_clr = '0;
    n_tests++;
    if ({flags, irq} !== 4'b0000) begin
      n_fail++;
      $display("FAIL flag_clr_cmp got flg=%b irq=%b exp 000 0", flags, irq);
    end
  endtask

  task automatic test_compare();
    exp_t e;
    int hits0;
    hits0 = 0;
    cfg_start(0, 9, 5, 12, 1'b0);
    for (int k = 0; k < 25; k++) sb.push_back(model(0, 9, 5, 12, k));
    for (int k = 0; k < 25; k++) begin
      if (k > 0) step();
      e = sb.pop_front();
      if (cmp_match[0]) hits0++;
      n_tests++;
      if ({tmr, pr_match, cmp_match, flags, irq} !== {e.tmr, e.pr, e.cmp, e.flg, |e.flg}) begin
        n_fail++;
        $display("FAIL compare k=%0d got tmr=%0d pr=%b cmp=%b flg=%b exp tmr=%0d pr=%b cmp=%b flg=%b",
                 k, tmr, pr_match, cmp_match, flags, e.tmr, e.pr, e.cmp, e.flg);
      end
    end
    n_tests++;
    if (hits0 != 2) begin
      n_fail++;
      $display("FAIL compare_count got %0d pulses exp 2", hits0);
    end
  endtask

  task automatic test_shadow_write();
    exp_t e;
    cfg_start(0, 9, 15, 15, 1'b0);
    for (int k = 0; k < 20; k++) begin
      e = '0;
      e.busy = 1'b1;
      if (k < 10) e.tmr = 16'(k);
      else begin
        e.tmr = 16'((k - 10) % 4);
        e.pr  = ((k - 10) % 4 == 0);
        e.flg = 3'b001;
      end
      sb.push_back(e);
    end
    for (int k = 0; k < 20; k++) begin
      if (k > 0) step();
      pr_we = 1'b0;
      e = sb.pop_front();
      n_tests++;
      if ({tmr, pr_match, cmp_match, flags} !== {e.tmr, e.pr, e.cmp, e.flg}) begin
        n_fail++;
        $display("FAIL shadow_write k=%0d got tmr=%0d pr=%b cmp=%b flg=%b exp tmr=%0d pr=%b cmp=%b flg=%b",
                 k, tmr, pr_match, cmp_match, flags, e.tmr, e.pr, e.cmp, e.flg);
      end
      if (k == 2) begin pr_we = 1'b1; pr_wdata = 16'd3; end
    end
  endtask

  task automatic test_one_shot();
    exp_t e;
    cfg_start(0, 2, 7, 7, 1'b1);
    for (int k = 0; k < 8; k++) begin
      e = '0;
      e.tmr  = (k < 3) ? 16'(k) : 16'd0;
      e.pr   = (k == 3);
      e.flg  = (k >= 3) ? 3'b001 : 3'b000;
      e.busy = (k < 3);
      sb.push_back(e);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      e = sb.pop_front();
      n_tests++;
      if ({tmr, pr_match, flags, busy} !== {e.tmr, e.pr, e.flg, e.busy}) begin
        n_fail++;
        $display("FAIL one_shot k=%0d got tmr=%0d pr=%b flg=%b busy=%b exp tmr=%0d pr=%b flg=%b busy=%b",
                 k, tmr, pr_match, flags, busy, e.tmr, e.pr, e.flg, e.busy);
      end
    end
    en = 1'b0; step();
    en = 1'b1; step();
    n_tests++;
    if ({tmr, busy} !== {16'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL one_shot_restart got tmr=%0d busy=%b exp 0 1", tmr, busy);
    end
    step();
    n_tests++;
    if (tmr !== 16'd1) begin
      n_fail++;
      $display("FAIL one_shot_count got tmr=%0d exp 1", tmr);
    end
  endtask

  task automatic test_pwm_async_reset();
    logic [1:0] pe;
    int highs, exp_highs;
    highs = 0;
`ifdef TIMER_PWM_EN
    exp_highs = 3;
`else
    exp_highs = 0;
`endif
    cfg_start(0, 9, 3, 15, 1'b0);
    for (int k = 0; k < 15; k++) sb.push_back(model(0, 9, 3, 15, k));
    for (int k = 0; k < 15; k++) begin
      exp_t e;
      if (k > 0) step();
      e = sb.pop_front();
`ifdef TIMER_PWM_EN
      pe = {1'b1, e.tmr < 16'd3};
`else
      pe = 2'b00;
`endif
      if (k < 10 && pwm_out[0]) highs++;
      n_tests++;
      if ({tmr, pwm_out} !== {e.tmr, pe}) begin
        n_fail++;
        $display("FAIL pwm k=%0d got tmr=%0d pwm=%b exp tmr=%0d pwm=%b", k, tmr, pwm_out, e.tmr, pe);
      end
    end
    n_tests++;
    if (highs != exp_highs) begin
      n_fail++;
      $display("FAIL pwm_duty got %0d high counts exp %0d", highs, exp_highs);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tmr, pwm_out, flags, busy, pr_match} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got tmr=%0d pwm=%b flg=%b busy=%b pr=%b exp all 0",
               tmr, pwm_out, flags, busy, pr_match);
    end
    step();
    rst_n = 1'b1; en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_period();
    test_prescale_flagclr();
    test_compare();
    test_shadow_write();
    test_one_shot();
    test_pwm_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_cmp_unit.md
Name: timer_cmp_unit

Overview:
- Parametrised timer/compare block for the SimpleRISC SoC peripheral set. It is the successor to the fixed 16-bit equality comparator used in the timer path.
- Contains a prescaled up-counter, a period register with shadow reload, and NCH compare channels.
- Provides per-event sticky flags, a combined interrupt, and a one-shot or continuous mode.
- Sits behind the peripheral bus glue; all config arrives as write strobes.

Parameters:
- WIDTH, 16, counter, period and compare width.
- NCH, 2, number of compare channels (1..8).
- PSC_W, 8, prescaler width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  run enable (level).
- one_shot  in  1  1 = stop after the first period match; sampled on IDLE->RUN.
- psc  in  PSC_W  prescale divisor minus 1; tick every psc+1 clocks.
- pr_we  in  1  period write strobe.
- pr_wdata  in  WIDTH  period value.
- cmp_we  in  NCH  per-channel compare write strobe.
- cmp_wdata  in  NCH*WIDTH  compare values; channel i is at [i*WIDTH +: WIDTH].
- flag_clr  in  NCH+1  write-1-to-clear; bit 0 = period flag, bit i+1 = channel i.
- tmr  out  WIDTH  current count.
- pr_match  out  1  one-cycle pulse on period event.
- cmp_match  out  NCH  one-cycle pulse per channel match.
- flags  out  NCH+1  sticky event flags, same bit map as flag_clr.
- irq  out  1  OR of flags.
- busy  out  1  high in RUN.
- pwm_out  out  NCH  PWM outputs (see Optional Feature).

Behaviour:
- Reset:
  - tmr=0, prescaler count=0, state=IDLE.
  - Period shadow and active = all ones; compare shadow and active = 0.
  - All outputs 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when en=1; one_shot is latched on this transition.
  - RUN->IDLE when en=0; tmr holds its value, prescaler count clears to 0.
  - RUN->DONE on a period event when latched one_shot=1; tmr=0 on entry.
  - DONE->IDLE when en=0.
  - DONE holds tmr=0 and generates no ticks.
- Prescaler:
  - Counts 0..psc only in RUN.
  - tick = (count==psc), then count wraps to 0.
  - psc=0 gives a tick every clock.
- Counter, evaluated on a tick:
  - If tmr==pr_active: tmr<=0, period event, pr_active<=pr_shadow, cmp_active<=cmp_shadow.
  - Otherwise tmr<=tmr+1.
  - There is no free-running wrap: the period match always wraps first. pr=all ones gives 2^WIDTH counts.
- Period edge cases:
  - pr_active=0 gives a period event on every tick; tmr stays 0.
- Compare:
  - Channel i match on a tick when tmr==cmp_active[i], using the pre-increment value.
  - A compare value greater than pr_active never matches.
  - A channel equal to pr_active matches on the same tick as the period event; both fire.
- Output latency:
  - pr_match and cmp_match are registered; they assert in the cycle after the tick edge.
  - That cycle is coincident with tmr showing its post-tick value (0 for a period event).
- Writes:
  - In RUN, writes go to the shadow only and take effect at the next period event.
  - In IDLE or DONE, writes update shadow and active in the same clock.
  - Simultaneous write and reload: the new write data goes to the shadow; active takes the old shadow.
- Flags:
  - Set on the same edge as the corresponding match pulse.
  - Set and clear in the same cycle: set wins.
  - irq is combinational OR of flags.
- Mid-operation reset:
  - rst_n low forces all reset values immediately, independent of clk.
  - Release is synchronised by the integration top, not here.

Optional Feature:
- Macro: TIMER_PWM_EN.
- Defined: pwm_out[i] is registered and equals (tmr < cmp_active[i]) while in RUN, 0 otherwise.
  - cmp=0 gives a constant 0.
  - cmp>pr_active gives a constant 1.
  - Because compare reloads at the period boundary, PWM updates are glitch-free.
- Undefined: pwm_out is tied to 0, no comparator logic is generated, and the port stays present.

Decomposition:
- Package timer_pkg holds:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Default WIDTH/NCH/PSC_W localparams.
  - Flag bit index constants: FLAG_PR=0, FLAG_CMP0=1.
- Sub-module timer_prescaler (PSC_W; inputs clk, rst_n, run, psc; output tick). Instantiated once.
- Compare channels are a generate loop, not a sub-module.

Test Plan:
- Reset, then psc=0, pr=4, en=1 -> tmr sequence 0,1,2,3,4,0; pr_match pulses one cycle with tmr=0; flags[0]=1; irq=1.
- psc=2, pr=3 -> tmr advances every 3 clocks; period event every 12 clocks; flag_clr[0]=1 coincident with the next pr_match -> flag stays 1.
- pr=9, cmp0=5, cmp1=12 -> cmp_match[0] pulses once per period after tmr 5->6; cmp_match[1] is never asserted.
- In RUN with pr=9, write pr=3 while tmr=2 -> tmr still reaches 9; after the wrap the period is 3 (0..3).
- one_shot=1, pr=2 -> tmr 0,1,2,0; state DONE; busy=0; tmr stays 0 with en still 1; en=0 then 1 restarts.
- With TIMER_PWM_EN defined: pr=9, cmp0=3 -> pwm_out[0] high for 3 of 10 counts; assert rst_n=0 mid-count -> tmr=0, pwm_out=0, flags=0 immediately.
